// File: rtl/rf_sched_pkg.sv
// Shared widths, write-back entry type and hazard helper for rf_write_scheduler.
package rf_sched_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 16;

  // One register-file write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // A source/destination conflicts only if it names a real register with a load outstanding.
  function automatic logic reg_busy(input logic [NUM_REGS-1:0]   pend,
                                    input logic [REG_ADDR_W-1:0] addr);
    return (addr != '0) && pend[addr];
  endfunction

endpackage

// File: rtl/lq_fifo.sv
// Load-return queue: synchronous FIFO of write-back entries, depth a power of two.
module lq_fifo
  import rf_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head_c,
  output logic      full_c,
  output logic      empty_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign head_c  = mem_q[rd_ptr_q];
  assign full_c  = (cnt_q == CNT_W'(DEPTH));
  assign empty_c = (cnt_q == '0);

  // Next-state for storage, pointers (wrap naturally at power-of-two depth) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
    end
    if (pop) begin
      rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    end
    if (push && !pop) begin
      cnt_d = CNT_W'(cnt_q + 1'b1);
    end else if (!push && pop) begin
      cnt_d = CNT_W'(cnt_q - 1'b1);
    end
  end

  // State registers; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler: arbitrates execute results against queued load
// returns and tracks outstanding loads to stall decode on RAW/WAW hazards.
// Optional feature: define RF_SCHED_STARVE_GUARD_EN to force a queue grant after
// STARVE_LIMIT consecutive denied cycles; otherwise execute has strict priority.
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int unsigned LQ_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_a_addr,
  input  logic [REG_ADDR_W-1:0] iss_b_addr,
  input  logic [REG_ADDR_W-1:0] iss_m_addr,
  input  logic [REG_ADDR_W-1:0] iss_p_addr,
  input  logic [REG_ADDR_W-1:0] iss_dst,
  input  logic                  iss_is_load,
  output logic                  iss_stall,
  input  logic                  exe_valid,
  input  logic [REG_ADDR_W-1:0] exe_addr,
  input  logic [DATA_W-1:0]     exe_data,
  output logic                  exe_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0]     rf_write_data,
  output logic [NUM_REGS-1:0]   pending
);

  logic [REG_ADDR_W-1:0] rf_write_addr_q, rf_write_addr_d;
  logic [DATA_W-1:0]     rf_write_data_q, rf_write_data_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  wb_entry_t lq_push_data_c;
  wb_entry_t lq_head_c;
  logic      lq_full_c;
  logic      lq_empty_c;
  logic      lq_push_c;
  logic      exe_wr_c;
  logic      force_q_c;
  logic      q_grant_c;
  logic      exe_grant_c;
  logic      sb_set_c;

  // Load-return queue; zero-destination returns are accepted but never stored.
  assign lq_push_data_c = '{addr: mem_addr, data: mem_data};
  assign lq_push_c      = mem_valid && !lq_full_c && (mem_addr != '0);

  lq_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lq_push_c),
    .push_data (lq_push_data_c),
    .pop       (q_grant_c),
    .head_c    (lq_head_c),
    .full_c    (lq_full_c),
    .empty_c   (lq_empty_c)
  );

`ifdef RF_SCHED_STARVE_GUARD_EN
  localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [STARVE_W-1:0] starve_q, starve_d;

  assign force_q_c = !lq_empty_c && (starve_q >= STARVE_W'(STARVE_LIMIT));

  // Count consecutive cycles the queue waits; any queue grant restarts the count.
  always_comb begin
    starve_d = starve_q;
    if (q_grant_c) begin
      starve_d = '0;
    end else if (!lq_empty_c && (starve_q < STARVE_W'(STARVE_LIMIT))) begin
      starve_d = STARVE_W'(starve_q + 1'b1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_limit;

  assign force_q_c           = 1'b0;
  assign unused_starve_limit = ^STARVE_LIMIT;
`endif

  // Single write port: execute first unless the queue is being forced through.
  assign exe_wr_c    = exe_valid && (exe_addr != '0);
  assign q_grant_c   = !lq_empty_c && (force_q_c || !exe_wr_c);
  assign exe_grant_c = exe_wr_c && !q_grant_c;

  assign exe_ready = !q_grant_c;
  assign mem_ready = !lq_full_c;

  // Decode holds while any named register still awaits a load return.
  assign iss_stall = iss_valid && (reg_busy(pending_q, iss_a_addr) ||
                                   reg_busy(pending_q, iss_b_addr) ||
                                   reg_busy(pending_q, iss_m_addr) ||
                                   reg_busy(pending_q, iss_p_addr) ||
                                   reg_busy(pending_q, iss_dst));

  assign sb_set_c = iss_valid && !iss_stall && iss_is_load && (iss_dst != '0);

  // Next write-port value and scoreboard; a same-cycle set beats the clear.
  always_comb begin
    rf_write_addr_d = '0;
    rf_write_data_d = rf_write_data_q;
    pending_d       = pending_q;
    if (exe_grant_c) begin
      rf_write_addr_d = exe_addr;
      rf_write_data_d = exe_data;
    end else if (q_grant_c) begin
      rf_write_addr_d = lq_head_c.addr;
      rf_write_data_d = lq_head_c.data;
    end
    if (q_grant_c) begin
      pending_d[lq_head_c.addr] = 1'b0;
    end
    if (sb_set_c) begin
      pending_d[iss_dst] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Write-port and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_addr_q <= '0;
      rf_write_data_q <= '0;
      pending_q       <= '0;
    end else begin
      rf_write_addr_q <= rf_write_addr_d;
      rf_write_data_q <= rf_write_data_d;
      pending_q       <= pending_d;
    end
  end

  assign rf_write_addr = rf_write_addr_q;
  assign rf_write_data = rf_write_data_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: write-port scoreboard plus per-scenario checks.
module tb_rf_write_scheduler;
  import rf_sched_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        iss_valid;
  logic [3:0]  iss_a_addr, iss_b_addr, iss_m_addr, iss_p_addr, iss_dst;
  logic        iss_is_load;
  logic        iss_stall;
  logic        exe_valid;
  logic [3:0]  exe_addr;
  logic [31:0] exe_data;
  logic        exe_ready;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [3:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [15:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  wb_entry_t exp_q[$];
  wb_entry_t mon_e;

  rf_write_scheduler #(
    .LQ_DEPTH     (2),
    .STARVE_LIMIT (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .iss_valid     (iss_valid),
    .iss_a_addr    (iss_a_addr),
    .iss_b_addr    (iss_b_addr),
    .iss_m_addr    (iss_m_addr),
    .iss_p_addr    (iss_p_addr),
    .iss_dst       (iss_dst),
    .iss_is_load   (iss_is_load),
    .iss_stall     (iss_stall),
    .exe_valid     (exe_valid),
    .exe_addr      (exe_addr),
    .exe_data      (exe_data),
    .exe_ready     (exe_ready),
    .mem_valid     (mem_valid),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_ready     (mem_ready),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every nonzero write must match the oldest expected write.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && rf_write_addr !== 4'd0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL wb_unexpected: got addr=%0d data=%h, expected no write", rf_write_addr, rf_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_write_addr !== mon_e.addr || rf_write_data !== mon_e.data)
          $display("FAIL wb_order: got addr=%0d data=%h, expected addr=%0d data=%h",
                   rf_write_addr, rf_write_data, mon_e.addr, mon_e.data);
        else n_pass++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_a_addr = 0; iss_b_addr = 0; iss_m_addr = 0; iss_p_addr = 0;
    iss_dst = 0; iss_is_load = 0;
    exe_valid = 0; exe_addr = 0; exe_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
  endtask

  task automatic issue_load(input logic [3:0] dst);
    iss_valid = 1; iss_is_load = 1; iss_dst = dst;
    tick();
    iss_valid = 0; iss_is_load = 0; iss_dst = 0;
  endtask

  task automatic test_reset();
    iss_valid = 1; iss_a_addr = 4'd5;
    #1;
    n_checks++; if (rf_write_addr !== 4'd0) $display("FAIL reset_addr: got %0d expected 0", rf_write_addr); else n_pass++;
    n_checks++; if (rf_write_data !== 32'd0) $display("FAIL reset_data: got %h expected 0", rf_write_data); else n_pass++;
    n_checks++; if (pending !== 16'd0) $display("FAIL reset_pending: got %h expected 0", pending); else n_pass++;
    n_checks++; if (iss_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", iss_stall); else n_pass++;
    n_checks++; if (exe_ready !== 1'b1) $display("FAIL reset_exe_ready: got %b expected 1", exe_ready); else n_pass++;
    n_checks++; if (mem_ready !== 1'b1) $display("FAIL reset_mem_ready: got %b expected 1", mem_ready); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_load_hazard();
    iss_valid = 1; iss_is_load = 1; iss_dst = 4'd5;
    #1;
    n_checks++; if (iss_stall !== 1'b0) $display("FAIL hz_issue_stall: got %b expected 0", iss_stall); else n_pass++;
    tick();
    n_checks++; if (pending !== 16'h0020) $display("FAIL hz_pending_set: got %h expected 0020", pending); else n_pass++;
    iss_is_load = 0; iss_dst = 0; iss_a_addr = 4'd5;
    mem_valid = 1; mem_addr = 4'd5; mem_data = 32'hDEADBEEF;
    push_exp(4'd5, 32'hDEADBEEF);
    #1;
    n_checks++; if (iss_stall !== 1'b1) $display("FAIL hz_raw_stall: got %b expected 1", iss_stall); else n_pass++;
    tick();
    mem_valid = 0;
    #1;
    n_checks++; if (iss_stall !== 1'b1) $display("FAIL hz_stall_hold: got %b expected 1", iss_stall); else n_pass++;
    tick();
    n_checks++; if (rf_write_addr !== 4'd5) $display("FAIL hz_wb_addr: got %0d expected 5", rf_write_addr); else n_pass++;
    n_checks++; if (iss_stall !== 1'b0) $display("FAIL hz_unstall: got %b expected 0", iss_stall); else n_pass++;
    n_checks++; if (pending !== 16'h0000) $display("FAIL hz_pending_clr: got %h expected 0000", pending); else n_pass++;
    idle_inputs();
    tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL hz_drain: got %0d left expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_contention();
    bit forced;
    bit r7_done = 0;
    issue_load(4'd7);
    for (int i = 0; i < 7; i++) begin
      exe_valid = 1; exe_addr = 4'd3; exe_data = 32'h11;
      mem_valid = (i == 0); mem_addr = 4'd7; mem_data = 32'h7777;
`ifdef RF_SCHED_STARVE_GUARD_EN
      forced = (i == 4);
`else
      forced = 0;
`endif
      #1;
      n_checks++;
      if (exe_ready !== !forced) $display("FAIL ct_exe_ready[%0d]: got %b expected %b", i, exe_ready, !forced);
      else n_pass++;
      if (forced) begin push_exp(4'd7, 32'h7777); r7_done = 1; end
      else push_exp(4'd3, 32'h11);
      tick();
    end
    idle_inputs();
    if (!r7_done) begin
      push_exp(4'd7, 32'h7777);
      #1;
      n_checks++; if (exe_ready !== 1'b0) $display("FAIL ct_drain_ready: got %b expected 0", exe_ready); else n_pass++;
    end
    tick();
    tick();
    n_checks++; if (pending !== 16'h0000) $display("FAIL ct_pending: got %h expected 0000", pending); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL ct_drain: got %0d left expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_full_queue();
    logic [3:0] maddr [3];
    logic [31:0] mdata [3];
    maddr[0] = 4'd8; maddr[1] = 4'd9; maddr[2] = 4'd10;
    mdata[0] = 32'h88; mdata[1] = 32'h99; mdata[2] = 32'hAA;
    for (int c = 0; c < 7; c++) begin
      exe_valid = (c < 4); exe_addr = 4'd3; exe_data = 32'h22;
      mem_valid = (c < 6); mem_addr = maddr[(c < 2) ? c : 2]; mem_data = mdata[(c < 2) ? c : 2];
      #1;
      if (c == 2 || c == 3 || c == 4) begin
        n_checks++; if (mem_ready !== 1'b0) $display("FAIL fq_full[%0d]: got %b expected 0", c, mem_ready); else n_pass++;
      end else if (c < 6) begin
        n_checks++; if (mem_ready !== 1'b1) $display("FAIL fq_ready[%0d]: got %b expected 1", c, mem_ready); else n_pass++;
      end
      if (c == 4) begin
        n_checks++; if (exe_ready !== 1'b0) $display("FAIL fq_qgrant: got exe_ready=%b expected 0", exe_ready); else n_pass++;
      end
      if (c < 4) push_exp(4'd3, 32'h22);
      else push_exp(maddr[c - 4], mdata[c - 4]);
      tick();
    end
    idle_inputs();
    tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL fq_drain: got %0d left expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_zero_reg();
    issue_load(4'd2);
    n_checks++; if (pending !== 16'h0004) $display("FAIL zr_pending_set: got %h expected 0004", pending); else n_pass++;
    exe_valid = 1; exe_addr = 4'd0; exe_data = 32'h55;
    #1;
    n_checks++; if (exe_ready !== 1'b1) $display("FAIL zr_exe_ready: got %b expected 1", exe_ready); else n_pass++;
    tick();
    exe_valid = 0;
    n_checks++; if (rf_write_addr !== 4'd0) $display("FAIL zr_exe_nowrite: got %0d expected 0", rf_write_addr); else n_pass++;
    mem_valid = 1; mem_addr = 4'd0; mem_data = 32'h66;
    #1;
    n_checks++; if (mem_ready !== 1'b1) $display("FAIL zr_mem_ready: got %b expected 1", mem_ready); else n_pass++;
    tick();
    mem_valid = 0;
    tick();
    n_checks++; if (rf_write_addr !== 4'd0) $display("FAIL zr_mem_nowrite: got %0d expected 0", rf_write_addr); else n_pass++;
    n_checks++; if (pending !== 16'h0004) $display("FAIL zr_pending_keep: got %h expected 0004", pending); else n_pass++;
    issue_load(4'd0);
    n_checks++; if (pending !== 16'h0004) $display("FAIL zr_dst0: got %h expected 0004", pending); else n_pass++;
    mem_valid = 1; mem_addr = 4'd2; mem_data = 32'h2222;
    push_exp(4'd2, 32'h2222);
    tick();
    mem_valid = 0;
    tick();
    n_checks++; if (pending !== 16'h0000) $display("FAIL zr_pending_clr: got %h expected 0000", pending); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL zr_drain: got %0d left expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    issue_load(4'd12);
    exe_valid = 1; exe_addr = 4'd3; exe_data = 32'h33;
    mem_valid = 1; mem_addr = 4'd12; mem_data = 32'hC;
    push_exp(4'd3, 32'h33);
    tick();
    mem_addr = 4'd13; mem_data = 32'hD;
    push_exp(4'd3, 32'h33);
    tick();
    idle_inputs();
    iss_valid = 1; iss_a_addr = 4'd12;
    #1;
    n_checks++; if (mem_ready !== 1'b0) $display("FAIL rm_pre_full: got %b expected 0", mem_ready); else n_pass++;
    n_checks++; if (iss_stall !== 1'b1) $display("FAIL rm_pre_stall: got %b expected 1", iss_stall); else n_pass++;
    rst_n = 0;
    #1;
    n_checks++; if (rf_write_addr !== 4'd0) $display("FAIL rm_addr: got %0d expected 0", rf_write_addr); else n_pass++;
    n_checks++; if (pending !== 16'd0) $display("FAIL rm_pending: got %h expected 0", pending); else n_pass++;
    n_checks++; if (mem_ready !== 1'b1) $display("FAIL rm_mem_ready: got %b expected 1", mem_ready); else n_pass++;
    n_checks++; if (iss_stall !== 1'b0) $display("FAIL rm_stall: got %b expected 0", iss_stall); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL rm_pre_drain: got %0d left expected 0", exp_q.size()); else n_pass++;
    tick();
    rst_n = 1;
    idle_inputs();
    tick();
    tick();
    n_checks++; if (rf_write_addr !== 4'd0) $display("FAIL rm_dropped: got %0d expected 0", rf_write_addr); else n_pass++;
    n_checks++; if (exe_ready !== 1'b1) $display("FAIL rm_exe_ready: got %b expected 1", exe_ready); else n_pass++;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    tick();
    test_reset();
    test_load_hazard();
    test_contention();
    test_full_queue();
    test_zero_reg();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
